// File: rtl/div_unit_if.sv
// ============================================================================
//  Module      : div_if
//  Description : Start/done handshake bundle between the execute stage and
//                the iterative DIV/DIVU unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_div;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   // Execute-stage side: issues operands, observes status/results
   modport master (
      output start, signed_div, dividend, divisor, cancel,
      input  busy, done, quotient, remainder
   );

   // Divider side
   modport slave (
      input  start, signed_div, dividend, divisor, cancel,
      output busy, done, quotient, remainder
   );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
//  Module      : div_unit
//  Description : Iterative radix-2 restoring divider for MIPS DIV/DIVU.
//                Divides operand magnitudes over 32 cycles, then applies
//                sign correction. Fixed 35-cycle start-to-done latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
   parameter int WIDTH = 32
) (
   input  wire logic clk,
   input  wire logic rst,
   div_if.slave      div_bus
);

   localparam logic [4:0] c_LAST_ITER = 5'd31;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_CALC = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next;

   // Latched request (original operands kept for the divide-by-zero result)
   logic               r_signed;
   logic [WIDTH-1:0]   r_dvd;
   logic [WIDTH-1:0]   r_dvs;

   // Iteration state: {partial remainder, quotient} and divisor magnitude
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mag_dvs;
   logic [4:0]         r_cnt;

   // Registered outputs
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_rem;

   logic               w_dvd_neg;
   logic               w_dvs_neg;
   logic [WIDTH-1:0]   w_dvd_mag;
   logic [WIDTH-1:0]   w_dvs_mag;
   logic [WIDTH:0]     w_hi;
   logic [WIDTH-1:0]   w_lo;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [2*WIDTH-1:0] w_calc_acc;
   logic [WIDTH-1:0]   w_quo_mag;
   logic [WIDTH-1:0]   w_rem_mag;
   logic [WIDTH-1:0]   w_fix_quo;
   logic [WIDTH-1:0]   w_fix_rem;
   logic               w_accept;

   // Sign bits only matter for DIV; DIVU treats every operand as positive.
   // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
   assign w_dvd_neg = r_signed & r_dvd[WIDTH-1];
   assign w_dvs_neg = r_signed & r_dvs[WIDTH-1];
   assign w_dvd_mag = w_dvd_neg ? ({WIDTH{1'b0}} - r_dvd) : r_dvd;
   assign w_dvs_mag = w_dvs_neg ? ({WIDTH{1'b0}} - r_dvs) : r_dvs;

   // One restoring step: shift {rem, quo} left, trial-subtract from the top 33 bits.
   // The kept difference is always below the divisor, so 32 bits hold it exactly.
   assign w_hi       = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_lo       = {r_acc[WIDTH-2:0], 1'b0};
   assign w_ge       = (w_hi >= {1'b0, r_mag_dvs});
   assign w_diff     = w_hi[WIDTH-1:0] - r_mag_dvs;
   assign w_calc_acc = w_ge ? {w_diff, w_lo[WIDTH-1:1], 1'b1}
                            : {w_hi[WIDTH-1:0], w_lo};

   // Sign correction; divide-by-zero overrides with all-ones / original dividend
   assign w_quo_mag = r_acc[WIDTH-1:0];
   assign w_rem_mag = r_acc[2*WIDTH-1:WIDTH];
   assign w_fix_quo = (r_dvs == {WIDTH{1'b0}}) ? {WIDTH{1'b1}}
                    : (w_dvd_neg ^ w_dvs_neg)   ? ({WIDTH{1'b0}} - w_quo_mag)
                    :                             w_quo_mag;
   assign w_fix_rem = (r_dvs == {WIDTH{1'b0}}) ? r_dvd
                    : w_dvd_neg                 ? ({WIDTH{1'b0}} - w_rem_mag)
                    :                             w_rem_mag;

   assign w_accept = (r_state == S_IDLE) & div_bus.start & ~div_bus.cancel;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; cancel aborts any in-flight state back to IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_PREP;
         S_PREP:  w_next = S_CALC;
         S_CALC:  if (r_cnt == c_LAST_ITER) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if ((r_state != S_IDLE) && div_bus.cancel) begin
         w_next = S_IDLE;
      end
   end

   // Operand latch, iteration datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_signed  <= 1'b0;
         r_dvd     <= '0;
         r_dvs     <= '0;
         r_acc     <= '0;
         r_mag_dvs <= '0;
         r_cnt     <= '0;
         r_quo     <= '0;
         r_rem     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_signed <= div_bus.signed_div;
                  r_dvd    <= div_bus.dividend;
                  r_dvs    <= div_bus.divisor;
               end
            end
            S_PREP: begin
               r_mag_dvs <= w_dvs_mag;
               r_acc     <= {{WIDTH{1'b0}}, w_dvd_mag};
               r_cnt     <= '0;
            end
            S_CALC: begin
               r_acc <= w_calc_acc;
               r_cnt <= r_cnt + 5'd1;
            end
            S_FIX: begin
               // An aborted op must leave the previous result visible
               if (!div_bus.cancel) begin
                  r_quo <= w_fix_quo;
                  r_rem <= w_fix_rem;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs registered so nothing combinational reaches the ports
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_next != S_IDLE);
         r_done <= (r_state == S_FIX) & ~div_bus.cancel;
      end
   end

   assign div_bus.busy      = r_busy;
   assign div_bus.done      = r_done;
   assign div_bus.quotient  = r_quo;
   assign div_bus.remainder = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  Module      : tb_div_unit
//  Description : Scoreboard bench for div_unit: directed DIV/DIVU vectors,
//                cancel, busy-time start and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   run   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   div_if #(.WIDTH(32)) bus();

   div_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .div_bus (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: counts busy cycles and checks each done against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.busy === 1'b1) run++;
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected no done (q=%h r=%h)",
                        bus.quotient, bus.remainder);
            end else begin
               e = sb.pop_front();
               check("latency_busy_cycles", 32'(run), 32'd35);
               check("quotient", bus.quotient, e.q);
               check("remainder", bus.remainder, e.r);
            end
         end
         if (bus.busy !== 1'b1) run = 0;
      end
   end

   // Issue one request; inputs are scrambled right after the latch cycle
   task automatic start_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                            input bit push, input logic [31:0] eq, input logic [31:0] er);
      exp_t e;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.signed_div = sd;
      bus.dividend   = a;
      bus.divisor    = b;
      if (push) begin
         e.q = eq;
         e.r = er;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start      = 1'b0;
      bus.signed_div = ~sd;
      bus.dividend   = ~a;
      bus.divisor    = b ^ 32'h5A5A_A5A5;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy === 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("busy_drops", {31'd0, bus.busy}, 32'd0);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL missing_done: got %0d pending results expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
      start_div(sd, a, b, 1'b1, eq, er);
      wait_idle();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.signed_div = 1'b0;
      bus.dividend   = '0;
      bus.divisor    = '0;
      bus.cancel     = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      check("reset_quotient", bus.quotient, 32'd0);
      check("reset_remainder", bus.remainder, 32'd0);
      rst = 1'b0;

      run_op(1'b0, 32'd100,       32'd7,        32'd14,       32'd2);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_op(1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
      run_op(1'b1, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678);
      run_op(1'b0, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678);
      run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE);

      // Cancel 10 cycles into 1000 / 3: no done, outputs keep previous result
      start_div(1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
      repeat (9) @(negedge clk);
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      check("cancel_busy", {31'd0, bus.busy}, 32'd0);
      check("cancel_quotient", bus.quotient, 32'd14);
      check("cancel_remainder", bus.remainder, 32'hFFFF_FFFE);

      // 9 / 4 with a start pulsed mid-operation that must be ignored
      start_div(1'b0, 32'd9, 32'd4, 1'b1, 32'd2, 32'd1);
      repeat (5) @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 32'd50;
      bus.divisor  = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
      @(negedge clk);
      check("busy_start_ignored", {31'd0, bus.busy}, 32'd0);

      // Cancel wins over a simultaneous start in IDLE
      @(negedge clk);
      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      check("idle_cancel_priority", {31'd0, bus.busy}, 32'd0);

      // Reset in the middle of a division
      start_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 32'd0, 32'd0);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_busy", {31'd0, bus.busy}, 32'd0);
      check("midreset_done", {31'd0, bus.done}, 32'd0);
      check("midreset_quotient", bus.quotient, 32'd0);
      check("midreset_remainder", bus.remainder, 32'd0);

      run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
